cond_select_reg: RTL
====================

Name: cond_select_reg

Overview:
- Parametrised, fully registered decision unit for the lint regression suite.
- Successor to the combinational if/else and case selectors. The partial if/else chains and partial case statements of those selectors are replaced by explicit hold registers, table lookups with defined defaults, and a mode select.
- Adds handshake-qualified capture, a saturating hold counter, and stale and miss flags.
- Sits between stimulus registers and checker logic as a clean, latch-free reference design.

Parameters:
- W, 2, width of operands a and b (W >= 2).
- SEL_W, 2, number of low operand bits used as table index (SEL_W <= W).
- ENTRIES, 3, number of valid table entries (1 <= ENTRIES <= 2**SEL_W).
- TABLE, 4'b0010, output bit per entry; bit i is the result for index i.
- DEFAULT_VAL, 1'b0, result for index >= ENTRIES.
- HOLD_LIMIT, 4, hold-count value at which stale asserts (>= 1).
- CNT_W, 4, hold counter width (2**CNT_W - 1 >= HOLD_LIMIT).

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, operands and mode valid this cycle.
- a, input, W, operand A.
- b, input, W, operand B.
- mode, input, 2, 0=PRIO, 1=LUT_A, 2=LUT_B, 3=PARITY.
- out, output, 1, registered decision.
- out_valid, output, 1, pulses one cycle after an accepted input.
- miss, output, 1, registered; last accepted LUT lookup hit index >= ENTRIES.
- hold_cnt, output, CNT_W, consecutive PRIO accepts that held out.
- stale, output, 1, hold_cnt >= HOLD_LIMIT.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. While rst=1 at a rising edge, all outputs take their reset values: out=0, out_valid=0, miss=0, hold_cnt=0, stale=0.
- rst overrides in_valid in the same cycle.
- Reset asserted mid-stream discards the input presented in that cycle.
- Accept: an input is accepted on a rising edge with in_valid=1 and rst=0. No backpressure.
- Latency: results appear exactly 1 cycle after accept, with out_valid=1 for that single cycle.
- Idle cycles (in_valid=0): out_valid=0; out, miss, hold_cnt and stale keep their values.
- FSM: two states.
  - IDLE: entered from reset, and from RESULT on any edge with no accept.
  - RESULT: entered on every accept. Back-to-back accepts stay in RESULT.
  - out_valid = (state == RESULT).
- PRIO mode, evaluated in order:
  - a[0]&b[0] -> out=1.
  - else |(a[W-1:1] | b[W-1:1]) -> out=0.
  - else HOLD: out keeps its previous value and hold_cnt increments, saturating at 2**CNT_W - 1.
- PRIO mode, non-HOLD result: hold_cnt clears to 0.
- LUT_A: idx = a[SEL_W-1:0]. LUT_B: idx = b[SEL_W-1:0].
  - idx < ENTRIES -> out=TABLE[idx], miss=0.
  - idx >= ENTRIES -> out=DEFAULT_VAL, miss=1.
- PARITY: out = ^(a ^ b).
- Non-LUT modes: miss clears to 0. Non-PRIO modes: hold_cnt clears to 0.
- stale is registered and updated in the same cycle as hold_cnt: stale = (next hold_cnt >= HOLD_LIMIT).
- Every case statement carries a default; no combinational feedback; every storage element is a flop.

Test Plan:
- rst=1 for 2 cycles with in_valid=1, mode=0, a=2'b01, b=2'b01 -> all outputs 0 during reset and on the first cycle after release.
- W=2, mode=0: accept a=01,b=01 -> next cycle out=1, out_valid=1. Then accept a=10,b=00 -> out=0, hold_cnt=0.
- mode=0, out=1: accept a=00,b=00 for 5 consecutive cycles -> out stays 1, hold_cnt=1..5, stale=1 from the 4th result. Then accept a=01,b=01 -> hold_cnt=0, stale=0.
- Defaults, mode=1: accept a=00, 01, 10, 11 back-to-back -> out=0,1,0,0; miss=0,0,0,1; out_valid high for 4 consecutive cycles.
- mode=2, b=01 -> out=1; then mode=3, a=10, b=11 -> out=1, miss=0. Idle cycle in between -> out_valid=0, out unchanged.
- Assert rst during a 3-deep back-to-back burst (mode=0, a=00, b=00, out=1, hold_cnt=2) -> next cycle outputs all 0, FSM in IDLE. The first post-reset accept behaves as from a fresh reset.

Source files
------------

// File: rtl/cond_select_reg.sv
// Registered decision unit: priority, table lookup or parity per accepted input.
// PRIO holds the previous result and counts consecutive holds with a saturating counter.
module cond_select_reg #(
    parameter int                      W           = 2,
    parameter int                      SEL_W       = 2,
    parameter int                      ENTRIES     = 3,
    parameter logic [2**SEL_W-1:0]     TABLE       = 4'b0010,
    parameter logic                    DEFAULT_VAL = 1'b0,
    parameter int                      HOLD_LIMIT  = 4,
    parameter int                      CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [1:0]       mode,
    output logic             out,
    output logic             out_valid,
    output logic             miss,
    output logic [CNT_W-1:0] hold_cnt,
    output logic             stale
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_RESULT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_MAX = '1;
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_LIMIT);

    state_t r_state;
    state_t w_state_n;

    logic             r_out;
    logic             r_miss;
    logic [CNT_W-1:0] r_hold;
    logic             r_stale;

    logic             w_accept;
    logic [SEL_W-1:0] w_idx;
    logic             w_hit;
    logic             w_out_n;
    logic             w_miss_n;
    logic [CNT_W-1:0] w_hold_n;
    logic             w_stale_n;

    assign w_accept = in_valid & ~rst;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_n = S_IDLE;
        case (r_state)
            S_IDLE:   w_state_n = w_accept ? S_RESULT : S_IDLE;
            S_RESULT: w_state_n = w_accept ? S_RESULT : S_IDLE;
            default:  w_state_n = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        out_valid = 1'b0;
        case (r_state)
            S_RESULT: out_valid = 1'b1;
            default:  out_valid = 1'b0;
        endcase
    end

    assign w_idx = (mode == 2'd2) ? b[SEL_W-1:0] : a[SEL_W-1:0];
    assign w_hit = 32'(w_idx) < ENTRIES;

    always_comb begin
        w_out_n  = r_out;
        w_miss_n = 1'b0;
        w_hold_n = '0;
        case (mode)
            2'd0: begin
                if (a[0] & b[0]) begin
                    w_out_n = 1'b1;
                end else if (|(a[W-1:1] | b[W-1:1])) begin
                    w_out_n = 1'b0;
                end else begin
                    w_out_n  = r_out;
                    w_hold_n = (r_hold == HOLD_MAX) ? HOLD_MAX
                                                    : r_hold + CNT_W'(1);
                end
            end
            2'd1, 2'd2: begin
                if (w_hit) begin
                    w_out_n  = TABLE[w_idx];
                    w_miss_n = 1'b0;
                end else begin
                    w_out_n  = DEFAULT_VAL;
                    w_miss_n = 1'b1;
                end
            end
            2'd3: begin
                w_out_n = ^(a ^ b);
            end
            default: begin
                w_out_n = r_out;
            end
        endcase
        w_stale_n = (w_hold_n >= HOLD_LIM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out   <= 1'b0;
            r_miss  <= 1'b0;
            r_hold  <= '0;
            r_stale <= 1'b0;
        end else if (in_valid) begin
            r_out   <= w_out_n;
            r_miss  <= w_miss_n;
            r_hold  <= w_hold_n;
            r_stale <= w_stale_n;
        end
    end

    assign out      = r_out;
    assign miss     = r_miss;
    assign hold_cnt = r_hold;
    assign stale    = r_stale;

endmodule
